// File: rtl/game_tick_scheduler.sv
// Game-state FSM plus shared scroll prescaler; emits one-cycle scroll/spawn enables.
// All outputs registered (state visible one cycle after sampling); no backpressure, pulses are fire-and-forget.
module game_tick_scheduler #(
    parameter int unsigned BASE_PERIOD    = 2048,
    parameter int unsigned MIN_PERIOD     = 256,
    parameter int unsigned STEP           = 128,
    parameter int unsigned LEVEL_UP_SCORE = 4,
    parameter int unsigned MAX_LEVEL      = 15,
    parameter int unsigned SPAWN_EVERY    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause_btn,
    input  logic       collision,
    input  logic       point,
    output logic       scroll_en,
    output logic       spawn_en,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic [3:0] level
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_OVER   = 2'd3;

    localparam int SW = $clog2(SPAWN_EVERY + 1);
    localparam int PW = $clog2(LEVEL_UP_SCORE + 1);

    logic [11:0]   tick_cnt;
    logic [SW-1:0] spawn_cnt;
    logic [PW-1:0] progress;

    logic [31:0] dec;
    logic [31:0] period;
    logic        wrap;
    logic        run_ok;
    logic        advance;
    logic        restart;
    logic        point_ok;

    // Clamp before subtracting so high levels never underflow the period.
    always_comb begin
        dec = 32'(level) * STEP;
        if (dec + MIN_PERIOD >= BASE_PERIOD) begin
            period = MIN_PERIOD;
        end else begin
            period = BASE_PERIOD - dec;
        end
    end

    assign wrap     = ({20'd0, tick_cnt} >= (period - 32'd1));
    assign run_ok   = (state == S_RUN) && !collision && !pause_btn;
    // The resume edge counts as a run cycle, so a pause of N cycles costs exactly N cycles.
    assign advance  = run_ok || ((state == S_PAUSED) && pause_btn);
    assign restart  = start && ((state == S_IDLE) || (state == S_OVER));
    assign point_ok = run_ok && point && (score != 8'hFF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            scroll_en <= 1'b0;
            spawn_en  <= 1'b0;
            score     <= 8'd0;
            level     <= 4'd0;
            tick_cnt  <= 12'd0;
            spawn_cnt <= '0;
            progress  <= '0;
        end else begin
            scroll_en <= 1'b0;
            spawn_en  <= 1'b0;
            if (restart) begin
                state     <= S_RUN;
                score     <= 8'd0;
                level     <= 4'd0;
                tick_cnt  <= 12'd0;
                spawn_cnt <= '0;
                progress  <= '0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (collision) begin
                            state <= S_OVER;
                        end else if (pause_btn) begin
                            state <= S_PAUSED;
                        end
                    end
                    S_PAUSED: begin
                        if (pause_btn) begin
                            state <= S_RUN;
                        end
                    end
                    default: ;
                endcase

                if (advance) begin
                    if (wrap) begin
                        tick_cnt  <= 12'd0;
                        scroll_en <= 1'b1;
                        if (spawn_cnt == SW'(SPAWN_EVERY - 1)) begin
                            spawn_cnt <= '0;
                            spawn_en  <= 1'b1;
                        end else begin
                            spawn_cnt <= spawn_cnt + SW'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 12'd1;
                    end
                end

                if (point_ok) begin
                    score <= score + 8'd1;
                    if (progress == PW'(LEVEL_UP_SCORE - 1)) begin
                        progress <= '0;
                        if (level != 4'(MAX_LEVEL)) begin
                            level <= level + 4'd1;
                        end
                    end else begin
                        progress <= progress + PW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: directed scenarios with absolute timing checks plus a randomized run
// against a transaction-level model of the game rules.
module tb_game_tick_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       pause_btn = 1'b0;
    logic       collision = 1'b0;
    logic       point = 1'b0;
    logic       scroll_en;
    logic       spawn_en;
    logic [1:0] state;
    logic [7:0] score;
    logic [3:0] level;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: ticks are counted per game, elapsed is run cycles since the last tick.
    int m_state, m_elapsed, m_ticks, m_score, m_level, m_prog;
    bit m_scroll, m_spawn;

    game_tick_scheduler #(
        .BASE_PERIOD(16), .MIN_PERIOD(4), .STEP(4),
        .LEVEL_UP_SCORE(2), .MAX_LEVEL(15), .SPAWN_EVERY(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pause_btn(pause_btn),
        .collision(collision), .point(point), .scroll_en(scroll_en),
        .spawn_en(spawn_en), .state(state), .score(score), .level(level)
    );

    always #5 clk = ~clk;

    wire [15:0] dvec = {state, score, level, scroll_en, spawn_en};

    function automatic logic [15:0] mvec();
        return {2'(m_state), 8'(m_score), 4'(m_level), m_scroll, m_spawn};
    endfunction

    function automatic int m_period(input int lvl);
        int p;
        p = 16 - lvl * 4;
        return (p < 4) ? 4 : p;
    endfunction

    task automatic m_clear();
        m_elapsed = 0; m_ticks = 0; m_score = 0; m_level = 0; m_prog = 0;
        m_scroll = 0; m_spawn = 0;
    endtask

    // Drive one cycle of inputs, advance the model by the game rules, land at posedge+1.
    task automatic step(input bit st, input bit pb, input bit col, input bit pt);
        bit adv;
        int per;
        start = st; pause_btn = pb; collision = col; point = pt;
        m_scroll = 0; m_spawn = 0; adv = 0;
        per = m_period(m_level);
        case (m_state)
            0, 3: if (st) begin m_state = 1; m_clear(); end
            1: begin
                if (col) m_state = 3;
                else if (pb) m_state = 2;
                else begin
                    adv = 1;
                    if (pt && m_score < 255) begin
                        m_score++;
                        m_prog++;
                        if (m_prog == 2) begin
                            m_prog = 0;
                            if (m_level < 15) m_level++;
                        end
                    end
                end
            end
            default: if (pb) begin m_state = 1; adv = 1; end
        endcase
        if (adv) begin
            if (m_elapsed + 1 >= per) begin
                m_elapsed = 0;
                m_ticks++;
                m_scroll = 1;
                m_spawn = (m_ticks % 3 == 0);
            end else begin
                m_elapsed++;
            end
        end
        @(posedge clk);
        #1;
        start = 0; pause_btn = 0; collision = 0; point = 0;
    endtask

    // Runs to the next scroll pulse, then returns cycles to the following one (-1 on timeout).
    task automatic measure_gap(output int g);
        int n;
        n = 0;
        while (!scroll_en && n < 100) begin step(0, 0, 0, 0); n++; end
        g = 0;
        do begin step(0, 0, 0, 0); g++; end while (!scroll_en && g < 100);
        if (!scroll_en) g = -1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dvec !== 16'd0) $display("FAIL reset_outputs: got %h expected 0000", dvec);
        else n_pass++;
        reset_n = 1'b1;
        m_state = 0;
        m_clear();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, (i % 3) == 0);
            n_checks++;
            if (dvec !== mvec()) $display("FAIL idle_hold: got %h expected %h", dvec, mvec());
            else n_pass++;
        end
    endtask

    task automatic test_run_ticks();
        int q_sc[$];
        int q_sp[$];
        step(1, 0, 0, 0);
        n_checks++;
        if (state !== 2'd1) $display("FAIL start_state: got %0d expected 1", state);
        else n_pass++;
        for (int i = 1; i <= 60; i++) begin
            step(0, 0, 0, 0);
            n_checks++;
            if (dvec !== mvec()) $display("FAIL run_model: got %h expected %h", dvec, mvec());
            else n_pass++;
            if (scroll_en) q_sc.push_back(i);
            if (spawn_en) q_sp.push_back(i);
        end
        n_checks++;
        if (q_sc.size() != 3 || q_sc[0] != 16 || q_sc[1] != 32 || q_sc[2] != 48)
            $display("FAIL scroll_times: got %0d pulses first %0d expected 3 at 16/32/48",
                     q_sc.size(), (q_sc.size() > 0) ? q_sc[0] : -1);
        else n_pass++;
        n_checks++;
        if (q_sp.size() != 1 || q_sp[0] != 48)
            $display("FAIL spawn_times: got %0d pulses first %0d expected 1 at 48",
                     q_sp.size(), (q_sp.size() > 0) ? q_sp[0] : -1);
        else n_pass++;
    endtask

    task automatic test_pause();
        int n, g;
        bit bad;
        n = 0;
        while (!scroll_en && n < 40) begin step(0, 0, 0, 0); n++; end
        g = 0; bad = 0;
        for (int i = 1; i <= 15; i++) begin
            step(0, (i == 5) || (i == 15), 0, (i == 8));
            g++;
            if (i >= 5 && i <= 14 && (state !== 2'd2 || scroll_en || spawn_en || score !== 8'(m_score))) bad = 1;
        end
        n_checks++;
        if (bad) $display("FAIL paused_frozen: state %0d score %0d expected paused with no enables", state, score);
        else n_pass++;
        while (!scroll_en && g < 80) begin step(0, 0, 0, 0); g++; end
        n_checks++;
        if (g != 26) $display("FAIL pause_delay: got gap %0d expected 26", g);
        else n_pass++;
        n_checks++;
        if (dvec !== mvec()) $display("FAIL pause_model: got %h expected %h", dvec, mvec());
        else n_pass++;
    endtask

    task automatic test_levels();
        int g;
        int pts[6]  = '{2, 2, 2, 8, 16, 4};
        int lvl[6]  = '{1, 2, 3, 7, 15, 15};
        int gap[6]  = '{12, 8, 4, 4, 4, 4};
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < pts[k]; j++) begin
                step(0, 0, 0, 1);
                n_checks++;
                if (dvec !== mvec()) $display("FAIL point_model: got %h expected %h", dvec, mvec());
                else n_pass++;
            end
            n_checks++;
            if (level !== 4'(lvl[k])) $display("FAIL level_after_points: got %0d expected %0d", level, lvl[k]);
            else n_pass++;
            measure_gap(g);
            n_checks++;
            if (g != gap[k]) $display("FAIL period_at_level: got %0d expected %0d", g, gap[k]);
            else n_pass++;
        end
        n_checks++;
        if (score !== 8'd34) $display("FAIL score_total: got %0d expected 34", score);
        else n_pass++;
    endtask

    task automatic test_collision();
        int en;
        step(0, 0, 1, 1);
        n_checks++;
        if (state !== 2'd3 || score !== 8'd34) $display("FAIL collide: got state %0d score %0d expected 3/34", state, score);
        else n_pass++;
        en = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, (i == 7), 0, (i % 2) == 0);
            if (scroll_en || spawn_en || score !== 8'd34) en++;
        end
        n_checks++;
        if (en != 0) $display("FAIL over_quiet: got %0d bad cycles expected 0", en);
        else n_pass++;
        step(1, 0, 0, 0);
        n_checks++;
        if ({state, score, level} !== {2'd1, 8'd0, 4'd0})
            $display("FAIL restart: got state %0d score %0d level %0d expected 1/0/0", state, score, level);
        else n_pass++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 305; i++) step(0, 0, 0, 1);
        n_checks++;
        if (score !== 8'd255 || level !== 4'd15) $display("FAIL saturate: got score %0d level %0d expected 255/15", score, level);
        else n_pass++;
        n_checks++;
        if (dvec !== mvec()) $display("FAIL saturate_model: got %h expected %h", dvec, mvec());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int en;
        step(1, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dvec !== 16'd0) $display("FAIL async_reset: got %h expected 0000", dvec);
        else n_pass++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_state = 0;
        m_clear();
        en = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 1);
            if (scroll_en || state !== 2'd0) en++;
        end
        n_checks++;
        if (en != 0) $display("FAIL post_reset_idle: got %0d bad cycles expected 0", en);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 30) == 0, ($urandom % 20) == 0, ($urandom % 80) == 0, ($urandom % 3) == 0);
            n_checks++;
            if (dvec !== mvec()) begin
                errs++;
                if (errs < 10) $display("FAIL random_model: cycle %0d got %h expected %h", i, dvec, mvec());
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_pause();
        test_levels();
        test_collision();
        test_saturate();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
